// File: rtl/serial_pkg.sv
// Shared definitions for the serial position receiver: byte FSM states and framing constants.
package serial_pkg;

   // Byte receiver states
   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHigh
   } rx_state_e;

   localparam int unsigned DATA_BITS       = 8;
   localparam int unsigned BYTES_PER_FRAME = 3;
   localparam logic        START_LVL       = 1'b0;
   localparam logic        STOP_LVL        = 1'b1;

endpackage

// File: rtl/receptor_serial_if.sv
// Serial line in, decoded position frame out.
interface receptor_serial_if;
   import serial_pkg::*;

   logic                 canal_serial;
   logic [DATA_BITS-1:0] x;
   logic [DATA_BITS-1:0] y;
   logic [DATA_BITS-1:0] z;
   logic                 valid;
   logic                 error;
   logic [1:0]           byte_idx;

   // Arm side: drives the line, observes the decoded frame
   modport master (
      output canal_serial,
      input  x, y, z, valid, error, byte_idx
   );

   // Receiver side
   modport slave (
      input  canal_serial,
      output x, y, z, valid, error, byte_idx
   );
endinterface

// File: rtl/serial_byte_rx.sv
// Single-byte UART-style receiver: synchroniser, start/data/stop FSM, idle-line counter.
module serial_byte_rx
   import serial_pkg::*;
#(
   parameter  int unsigned CLKS_PER_BIT = 16,
   parameter  int unsigned GAP_LIMIT    = 64,
   localparam int unsigned GapW         = $clog2(GAP_LIMIT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 canal_serial,
   output logic [DATA_BITS-1:0] rx_byte,
   output logic                 byte_ok,
   output logic                 byte_err,
   output logic [GapW-1:0]      line_idle_cnt
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BitW = $clog2(DATA_BITS);

   localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);
   localparam logic [GapW-1:0] GapMax   = GapW'(GAP_LIMIT);

   logic                 sync1_q;
   logic                 line_q;
   rx_state_e            state_q;
   logic [CntW-1:0]      cnt_q;
   logic [BitW-1:0]      bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [GapW-1:0]      gap_q;

   // Two-flop synchroniser; resets to the idle (high) level so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         line_q  <= 1'b1;
      end else begin
         sync1_q <= canal_serial;
         line_q  <= sync1_q;
      end
   end

   // Byte FSM: half-bit start check, mid-bit data sampling, stop validation, idle-gap counting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         gap_q    <= '0;
         rx_byte  <= '0;
         byte_ok  <= 1'b0;
         byte_err <= 1'b0;
      end else begin
         byte_ok  <= 1'b0;
         byte_err <= 1'b0;

         // Any low level breaks an idle gap
         if (line_q == START_LVL) begin
            gap_q <= '0;
         end

         unique case (state_q)
            StIdle: begin
               if (line_q == START_LVL) begin
                  state_q <= StStart;
                  cnt_q   <= '0;
               end else if (gap_q != GapMax) begin
                  gap_q <= gap_q + 1'b1;
               end
            end

            StStart: begin
               if (cnt_q == HalfLast) begin
                  cnt_q <= '0;
                  bit_q <= '0;
                  // A start bit that is gone by mid-bit was a glitch: quietly return
                  state_q <= (line_q == START_LVL) ? StData : StIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            StData: begin
               if (cnt_q == FullLast) begin
                  cnt_q   <= '0;
                  shift_q <= {line_q, shift_q[DATA_BITS-1:1]};
                  if (bit_q == LastBit) begin
                     state_q <= StStop;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            StStop: begin
               if (cnt_q == FullLast) begin
                  cnt_q <= '0;
                  if (line_q == STOP_LVL) begin
                     rx_byte <= shift_q;
                     byte_ok <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     byte_err <= 1'b1;
                     state_q  <= StWaitHigh;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            StWaitHigh: begin
               // Do not treat a held-low line as a fresh start bit
               if (line_q == STOP_LVL) begin
                  state_q <= StIdle;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

   assign line_idle_cnt = gap_q;

endmodule

// File: rtl/receptor_serial.sv
// Position frame receiver: assembles three bytes into x/y/z and commits them atomically.
module receptor_serial
   import serial_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned GAP_BITS     = 4
) (
   input  logic               clk,
   input  logic               rst,
   receptor_serial_if.slave   bus
);

   localparam int unsigned GapLimit = CLKS_PER_BIT * GAP_BITS;
   localparam int unsigned GapW     = $clog2(GapLimit + 1);
   localparam logic [1:0]  LastIdx  = 2'(BYTES_PER_FRAME - 1);

   logic [DATA_BITS-1:0] rx_byte;
   logic                 byte_ok;
   logic                 byte_err;
   logic [GapW-1:0]      idle_cnt;
   logic                 gap_trunc;

   logic [1:0]           idx_q;
   logic [DATA_BITS-1:0] shadow0_q;
   logic [DATA_BITS-1:0] shadow1_q;
   logic [DATA_BITS-1:0] x_q;
   logic [DATA_BITS-1:0] y_q;
   logic [DATA_BITS-1:0] z_q;
   logic                 valid_q;
   logic                 error_q;

   serial_byte_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .GAP_LIMIT    (GapLimit)
   ) u_byte_rx (
      .clk           (clk),
      .rst           (rst),
      .canal_serial  (bus.canal_serial),
      .rx_byte       (rx_byte),
      .byte_ok       (byte_ok),
      .byte_err      (byte_err),
      .line_idle_cnt (idle_cnt)
   );

   // A long idle gap in the middle of a frame means the sender gave up on it
   assign gap_trunc = (idle_cnt == GapW'(GapLimit)) && (idx_q != 2'd0);

   // Frame assembly: shadow bytes until the third arrives, then commit all three at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= 2'd0;
         shadow0_q <= '0;
         shadow1_q <= '0;
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         if (byte_err || gap_trunc) begin
            idx_q     <= 2'd0;
            shadow0_q <= '0;
            shadow1_q <= '0;
            error_q   <= 1'b1;
         end else if (byte_ok) begin
            if (idx_q == LastIdx) begin
               x_q     <= shadow0_q;
               y_q     <= shadow1_q;
               z_q     <= rx_byte;
               valid_q <= 1'b1;
               idx_q   <= 2'd0;
            end else begin
               if (idx_q == 2'd0) begin
                  shadow0_q <= rx_byte;
               end else begin
                  shadow1_q <= rx_byte;
               end
               idx_q <= idx_q + 1'b1;
            end
         end
      end
   end

   assign bus.x        = x_q;
   assign bus.y        = y_q;
   assign bus.z        = z_q;
   assign bus.valid    = valid_q;
   assign bus.error    = error_q;
   assign bus.byte_idx = idx_q;

endmodule

// File: tb/tb_receptor_serial.sv
// Directed bench for receptor_serial: frame scoreboard plus per-cycle output checks.
module tb_receptor_serial;

   localparam int unsigned CPB = 16;
   localparam int unsigned GB  = 4;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] z;
   } frame_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   longint cyc = 0;

   receptor_serial_if bus ();

   receptor_serial #(
      .CLKS_PER_BIT (CPB),
      .GAP_BITS     (GB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int     vectors     = 0;
   int     miscompares = 0;
   frame_t exp_q[$];
   logic [7:0] cur_x = 8'h00, cur_y = 8'h00, cur_z = 8'h00;
   int     valid_cnt = 0;
   int     err_cnt   = 0;
   longint last_valid_cyc = 0, prev_valid_cyc = 0, err_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the frame scoreboard
   always @(negedge clk) begin
      if (rst) begin
         cur_x = 8'h00;
         cur_y = 8'h00;
         cur_z = 8'h00;
         chk("rst_x", {24'h0, bus.x}, 32'h0);
         chk("rst_y", {24'h0, bus.y}, 32'h0);
         chk("rst_z", {24'h0, bus.z}, 32'h0);
         chk("rst_valid", {31'h0, bus.valid}, 32'h0);
         chk("rst_error", {31'h0, bus.error}, 32'h0);
         chk("rst_byte_idx", {30'h0, bus.byte_idx}, 32'h0);
      end else begin
         chk("valid_error_excl", {31'h0, bus.valid & bus.error}, 32'h0);
         if (bus.valid) begin
            valid_cnt++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_valid: got valid=1, expected no frame (cycle %0d)", cyc);
            end else begin
               frame_t f;
               f = exp_q.pop_front();
               cur_x = f.x;
               cur_y = f.y;
               cur_z = f.z;
            end
         end
         // Outputs must always equal the last complete frame
         chk("x", {24'h0, bus.x}, {24'h0, cur_x});
         chk("y", {24'h0, bus.y}, {24'h0, cur_y});
         chk("z", {24'h0, bus.z}, {24'h0, cur_z});
         if (bus.error) begin
            err_cnt++;
            err_cyc = cyc;
         end
      end
   end

   task automatic idle_bits(input int n);
      bus.canal_serial = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      bus.canal_serial = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   task automatic send_frame(input logic [7:0] fx, input logic [7:0] fy, input logic [7:0] fz);
      exp_q.push_back('{x: fx, y: fy, z: fz});
      send_byte(fx, 1'b1);
      send_byte(fy, 1'b1);
      send_byte(fz, 1'b1);
   endtask

   initial begin
      int v0, e0;
      longint idle_start;
      logic [7:0] part;

      bus.canal_serial = 1'b1;
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("reset_x_literal", {24'h0, bus.x}, 32'h0);
      chk("reset_idx_literal", {30'h0, bus.byte_idx}, 32'h0);

      // 1: clean frame then long idle
      idle_bits(2);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h12, 8'h34, 8'h56);
      idle_bits(3000);
      chk("t1_valid_count", valid_cnt - v0, 1);
      chk("t1_error_count", err_cnt - e0, 0);
      chk("t1_x", {24'h0, bus.x}, 32'h12);
      chk("t1_y", {24'h0, bus.y}, 32'h34);
      chk("t1_z", {24'h0, bus.z}, 32'h56);

      // 2: short low glitch on idle line
      v0 = valid_cnt; e0 = err_cnt;
      bus.canal_serial = 1'b0;
      repeat (4) @(negedge clk);
      idle_bits(10);
      chk("t2_valid_count", valid_cnt - v0, 0);
      chk("t2_error_count", err_cnt - e0, 0);
      chk("t2_byte_idx", {30'h0, bus.byte_idx}, 32'h0);
      chk("t2_x_kept", {24'h0, bus.x}, 32'h12);

      // 3: bad stop bit on byte y, then a good frame
      v0 = valid_cnt; e0 = err_cnt;
      send_byte(8'h11, 1'b1);
      chk("t3_byte_idx_after_x", {30'h0, bus.byte_idx}, 32'h1);
      send_byte(8'h22, 1'b0);
      idle_bits(10);
      chk("t3_error_count", err_cnt - e0, 1);
      chk("t3_valid_count", valid_cnt - v0, 0);
      chk("t3_byte_idx", {30'h0, bus.byte_idx}, 32'h0);
      chk("t3_y_kept", {24'h0, bus.y}, 32'h34);
      send_frame(8'hA1, 8'hB2, 8'hC3);
      idle_bits(10);
      chk("t3_valid_after", valid_cnt - v0, 1);
      chk("t3_x_new", {24'h0, bus.x}, 32'hA1);
      chk("t3_z_new", {24'h0, bus.z}, 32'hC3);

      // 4: truncated frame ended by an idle gap
      e0 = err_cnt; v0 = valid_cnt;
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      chk("t4_byte_idx_2", {30'h0, bus.byte_idx}, 32'h2);
      idle_start = cyc;
      idle_bits(10);
      chk("t4_error_count", err_cnt - e0, 1);
      chk("t4_byte_idx", {30'h0, bus.byte_idx}, 32'h0);
      chk("t4_gap_timing_ok", {31'h0, (err_cyc - idle_start >= 56) && (err_cyc - idle_start <= 72)},
          32'h1);
      chk("t4_x_kept", {24'h0, bus.x}, 32'hA1);
      send_frame(8'h01, 8'h02, 8'h03);
      idle_bits(10);
      chk("t4_valid_count", valid_cnt - v0, 1);
      chk("t4_y_new", {24'h0, bus.y}, 32'h02);

      // 5: reset in the middle of byte x data bits
      part = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(part[i]);
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_x_reset", {24'h0, bus.x}, 32'h0);
      chk("t5_valid_reset", {31'h0, bus.valid}, 32'h0);
      chk("t5_idx_reset", {30'h0, bus.byte_idx}, 32'h0);
      #2 rst = 1'b0;
      v0 = valid_cnt; e0 = err_cnt;
      idle_bits(5);
      send_frame(8'h7F, 8'h80, 8'hFF);
      idle_bits(10);
      chk("t5_valid_count", valid_cnt - v0, 1);
      chk("t5_error_count", err_cnt - e0, 0);
      chk("t5_x", {24'h0, bus.x}, 32'h7F);
      chk("t5_z", {24'h0, bus.z}, 32'hFF);

      // 6: two frames back-to-back
      v0 = valid_cnt;
      send_frame(8'h00, 8'hFF, 8'h55);
      send_frame(8'hAA, 8'h0F, 8'hF0);
      idle_bits(10);
      chk("t6_valid_count", valid_cnt - v0, 2);
      chk("t6_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(30 * CPB));
      chk("t6_x", {24'h0, bus.x}, 32'hAA);
      chk("t6_y", {24'h0, bus.y}, 32'h0F);
      chk("t6_z", {24'h0, bus.z}, 32'hF0);

      chk("all_frames_seen", 32'(exp_q.size()), 32'h0);
      chk("total_errors", err_cnt, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
